// File: rtl/spi_pkg.sv
// Register map, bit positions and FSM encodings shared by the
// SPI flash read sequencer and its per-byte bus engine.
package spi_pkg;
    localparam logic [31:0] REG_STATUS  = 32'h0;
    localparam logic [31:0] REG_CONTROL = 32'h4;
    localparam logic [31:0] REG_DATA    = 32'h8;

    localparam int ST_FIN  = 0;
    localparam int ST_BUSY = 1;
    localparam int CTL_GO  = 0;
    localparam int CTL_CS  = 1;

    typedef enum logic [2:0] {
        PH_IDLE, PH_CMD, PH_ADR, PH_DAT, PH_OUT, PH_REL
    } phase_e;

    typedef enum logic [2:0] {
        BS_LOAD, BS_GO, BS_WFIN, BS_CLR, BS_WIDLE, BS_READ
    } step_e;

    function automatic logic [31:0] ctl_word(
        input logic [29:0] div,
        input logic        cs,
        input logic        go
    );
        logic [31:0] w;
        w         = {div, 2'b00};
        w[CTL_CS] = cs;
        w[CTL_GO] = go;
        return w;
    endfunction
endpackage

// File: rtl/spi_byte_xfer.sv
// One SPI byte exchange as a chain of controller bus ops:
// LOAD, GO, WFIN, CLR, WIDLE, READ.
module spi_byte_xfer
    import spi_pkg::*;
#(
    parameter logic [31:0] SPI_BASE = 32'hd000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        go,
    input  logic [7:0]  tx_byte,
    input  logic [29:0] clkdiv,
    output logic [7:0]  rx_byte,
    output logic        ack,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wmask,
    output logic        m_wen,
    output logic        m_ren,
    input  logic [31:0] m_rdata,
    input  logic        m_ready
);
    step_e st_q, st_d;
    logic  unused_rdata;

    assign unused_rdata = ^{m_rdata[31:16], m_rdata[7:2]};
    assign rx_byte      = m_rdata[15:8];

    always_ff @(posedge clk) begin
        if (rst) st_q <= BS_LOAD;
        else     st_q <= st_d;
    end

    // LOAD doubles as the idle state so back-to-back bytes have no gap
    always_comb begin
        st_d    = st_q;
        ack     = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        m_wmask = '0;
        m_wen   = 1'b0;
        m_ren   = 1'b0;
        unique case (st_q)
            BS_LOAD: if (go) begin
                m_addr  = SPI_BASE + REG_DATA;
                m_wdata = {24'h0, tx_byte};
                m_wmask = 4'b0001;
                m_wen   = 1'b1;
                if (m_ready) st_d = BS_GO;
            end
            BS_GO: begin
                m_addr  = SPI_BASE + REG_CONTROL;
                m_wdata = ctl_word(clkdiv, 1'b1, 1'b1);
                m_wmask = 4'hf;
                m_wen   = 1'b1;
                if (m_ready) st_d = BS_WFIN;
            end
            BS_WFIN: begin
                m_addr = SPI_BASE + REG_STATUS;
                m_ren  = 1'b1;
                if (m_ready && m_rdata[ST_FIN]) st_d = BS_CLR;
            end
            BS_CLR: begin
                m_addr  = SPI_BASE + REG_CONTROL;
                m_wdata = ctl_word(clkdiv, 1'b1, 1'b0);
                m_wmask = 4'hf;
                m_wen   = 1'b1;
                if (m_ready) st_d = BS_WIDLE;
            end
            BS_WIDLE: begin
                m_addr = SPI_BASE + REG_STATUS;
                m_ren  = 1'b1;
                if (m_ready && !m_rdata[ST_BUSY]) st_d = BS_READ;
            end
            BS_READ: begin
                m_addr = SPI_BASE + REG_DATA;
                m_ren  = 1'b1;
                if (m_ready) begin
                    ack  = 1'b1;
                    st_d = BS_LOAD;
                end
            end
            default: st_d = BS_LOAD;
        endcase
    end
endmodule

// File: rtl/spi_flash_read_seq.sv
// Flash read sequencer: command, address and dummy bytes through the
// SPI controller, with received data bytes on a valid/ready stream.
module spi_flash_read_seq
    import spi_pkg::*;
#(
    parameter logic [31:0] SPI_BASE   = 32'hd000,
    parameter int          ADDR_BYTES = 3,
    parameter int          LEN_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       cmd,
    input  logic [31:0]      flash_addr,
    input  logic [LEN_W-1:0] len,
    input  logic [29:0]      clkdiv,
    output logic             busy,
    output logic             done,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic [31:0]      m_addr,
    output logic [31:0]      m_wdata,
    output logic [3:0]       m_wmask,
    output logic             m_wen,
    output logic             m_ren,
    input  logic [31:0]      m_rdata,
    input  logic             m_ready
);
    phase_e           ph_q, ph_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [31:0]      adr_q, adr_d;
    logic [1:0]       an_q, an_d;
    logic [7:0]       cmd_q, cmd_d;
    logic [7:0]       rxd_q, rxd_d;
    logic             rxv_q, rxv_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             x_go, x_ack, x_wen, x_ren;
    logic [7:0]       x_tx, x_rx;
    logic [31:0]      x_addr, x_wdata;
    logic [3:0]       x_wmask;

    spi_byte_xfer #(.SPI_BASE(SPI_BASE)) u_xfer (
        .clk     (clk),
        .rst     (rst),
        .go      (x_go),
        .tx_byte (x_tx),
        .clkdiv  (clkdiv),
        .rx_byte (x_rx),
        .ack     (x_ack),
        .m_addr  (x_addr),
        .m_wdata (x_wdata),
        .m_wmask (x_wmask),
        .m_wen   (x_wen),
        .m_ren   (x_ren),
        .m_rdata (m_rdata),
        .m_ready (m_ready)
    );

    assign busy     = busy_q;
    assign done     = done_q;
    assign rx_data  = rxd_q;
    assign rx_valid = rxv_q;

    // Reset lands in RELEASE so an aborted transfer never leaves CS asserted
    always_ff @(posedge clk) begin
        if (rst) begin
            ph_q   <= PH_REL;
            len_q  <= '0;
            adr_q  <= '0;
            an_q   <= '0;
            cmd_q  <= '0;
            rxd_q  <= '0;
            rxv_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            ph_q   <= ph_d;
            len_q  <= len_d;
            adr_q  <= adr_d;
            an_q   <= an_d;
            cmd_q  <= cmd_d;
            rxd_q  <= rxd_d;
            rxv_q  <= rxv_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    always_comb begin
        ph_d   = ph_q;
        len_d  = len_q;
        adr_d  = adr_q;
        an_d   = an_q;
        cmd_d  = cmd_q;
        rxd_d  = rxd_q;
        rxv_d  = rxv_q;
        busy_d = busy_q;
        done_d = 1'b0;
        x_go   = 1'b0;
        x_tx   = 8'h00;
        if (rxv_q && rx_ready) rxv_d = 1'b0;
        unique case (ph_q)
            PH_IDLE: if (start) begin
                ph_d   = PH_CMD;
                busy_d = 1'b1;
                len_d  = len;
                cmd_d  = cmd;
                adr_d  = flash_addr << (8 * (4 - ADDR_BYTES));
                an_d   = 2'(ADDR_BYTES - 1);
            end
            PH_CMD: begin
                x_go = 1'b1;
                x_tx = cmd_q;
                if (x_ack) ph_d = PH_ADR;
            end
            PH_ADR: begin
                x_go = 1'b1;
                x_tx = adr_q[31:24];
                if (x_ack) begin
                    adr_d = adr_q << 8;
                    an_d  = an_q - 2'd1;
                    if (an_q == 2'd0)
                        ph_d = (len_q == '0) ? PH_REL : PH_DAT;
                end
            end
            PH_DAT: begin
                x_go = 1'b1;
                if (x_ack) begin
                    rxd_d = x_rx;
                    rxv_d = 1'b1;
                    len_d = len_q - LEN_W'(1);
                    ph_d  = PH_OUT;
                end
            end
            PH_OUT: if (rxv_q && rx_ready) begin
                ph_d = (len_q == '0) ? PH_REL : PH_DAT;
            end
            PH_REL: if (m_ready) begin
                ph_d   = PH_IDLE;
                done_d = busy_q;
                busy_d = 1'b0;
            end
            default: ph_d = PH_REL;
        endcase
    end

    always_comb begin
        m_addr  = x_addr;
        m_wdata = x_wdata;
        m_wmask = x_wmask;
        m_wen   = x_wen;
        m_ren   = x_ren;
        if (ph_q == PH_REL) begin
            m_addr  = SPI_BASE + REG_CONTROL;
            m_wdata = ctl_word(clkdiv, 1'b0, 1'b0);
            m_wmask = 4'hf;
            m_wen   = 1'b1;
            m_ren   = 1'b0;
        end
        if (rst) begin
            m_addr  = '0;
            m_wdata = '0;
            m_wmask = '0;
            m_wen   = 1'b0;
            m_ren   = 1'b0;
        end
    end
endmodule

// File: tb/tb_spi_flash_read_seq.sv
// Bench for spi_flash_read_seq: SPI controller and flash models on the
// bus, stream consumer, and directed plus randomized read transfers.
module tb_spi_flash_read_seq;
    localparam logic [31:0] BASE = 32'hd000;

    logic        clk, rst, start;
    logic [7:0]  cmd;
    logic [31:0] flash_addr;
    logic [15:0] len;
    logic [29:0] clkdiv;
    logic        busy, done, rx_valid, rx_ready;
    logic [7:0]  rx_data;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [3:0]  m_wmask;
    logic        m_wen, m_ren, m_ready;

    spi_flash_read_seq dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cmd        (cmd),
        .flash_addr (flash_addr),
        .len        (len),
        .clkdiv     (clkdiv),
        .busy       (busy),
        .done       (done),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .m_addr     (m_addr),
        .m_wdata    (m_wdata),
        .m_wmask    (m_wmask),
        .m_wen      (m_wen),
        .m_ren      (m_ren),
        .m_rdata    (m_rdata),
        .m_ready    (m_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0, errors = 0;
    int rel_cnt = 0, done_cnt = 0;
    int v_both = 0, v_hold = 0, v_rxhold = 0, v_bp = 0, v_cs = 0, v_div = 0;
    bit mr_rand = 0, rr_rand = 0, bp = 0, dly_rand = 0;
    int hold = 0;
    logic [7:0] mosi[$];
    logic [7:0] rxq[$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // SPI controller + flash: byte n>=4 of a CS session returns addr[7:0]+(n-4)
    logic       mdl_fin = 0, mdl_go = 0, mdl_sh = 0;
    logic [1:0] mdl_cnt = 0;
    logic [7:0] mdl_tx = 0, mdl_rx = 0, mdl_pend = 0;
    bit         cs_m = 0;
    int         sidx = 0;
    logic [23:0] saddr = 0;

    always_comb begin
        m_rdata = 32'h0;
        if (m_addr == BASE)
            m_rdata = {30'h0, mdl_go | mdl_sh, mdl_fin};
        else if (m_addr == BASE + 32'h8)
            m_rdata = {16'h0, mdl_rx, mdl_tx};
    end

    always @(posedge clk) begin
        logic [7:0] b;
        int d;
        if (mdl_sh) begin
            if (mdl_cnt == 2'd0) begin
                mdl_sh  <= 1'b0;
                mdl_fin <= 1'b1;
                mdl_rx  <= mdl_pend;
            end else mdl_cnt <= mdl_cnt - 2'd1;
        end
        if (m_ready && m_wen && m_addr == BASE + 32'h8 && m_wmask[0])
            mdl_tx <= m_wdata[7:0];
        if (m_ready && m_wen && m_addr == BASE + 32'h4) begin
            if (!m_wdata[1]) begin
                rel_cnt++;
                cs_m = 0;
                mdl_go  <= 1'b0;
                mdl_fin <= 1'b0;
                mdl_sh  <= 1'b0;
            end else begin
                if (!cs_m) begin
                    sidx  = 0;
                    saddr = 0;
                end
                cs_m = 1;
                if (m_wdata[0] && !mdl_go) begin
                    mosi.push_back(mdl_tx);
                    if (sidx >= 1 && sidx <= 3) saddr = {saddr[15:0], mdl_tx};
                    b = (sidx >= 4) ? 8'(saddr[7:0] + 8'(sidx - 4))
                                    : 8'(sidx ^ 8'h5a);
                    sidx++;
                    d = dly_rand ? int'($urandom_range(0, 3)) : 0;
                    mdl_go <= 1'b1;
                    if (d == 0) begin
                        mdl_fin <= 1'b1;
                        mdl_rx  <= b;
                    end else begin
                        mdl_sh   <= 1'b1;
                        mdl_cnt  <= 2'(d - 1);
                        mdl_pend <= b;
                        mdl_fin  <= 1'b0;
                    end
                end else if (!m_wdata[0]) begin
                    mdl_go  <= 1'b0;
                    mdl_fin <= 1'b0;
                end
            end
        end
        if (rx_valid && rx_ready && !rst) rxq.push_back(rx_data);
        if (done) done_cnt++;
    end

    initial begin
        m_ready  = 1'b1;
        rx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            m_ready = mr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bp) begin
                if (rx_valid) begin
                    hold++;
                    rx_ready = (hold > 20);
                end else begin
                    hold = 0;
                    rx_ready = 1'b0;
                end
            end else if (rr_rand) rx_ready = 1'($urandom_range(0, 1));
            else rx_ready = 1'b1;
        end
    end

    logic [69:0] prev_bus;
    logic [7:0]  prev_rxd;
    bit          pend = 0, stall = 0;

    always @(negedge clk) begin
        if (m_wen && m_ren) v_both++;
        if (!rst && pend && {m_addr, m_wdata, m_wmask, m_wen, m_ren} !== prev_bus)
            v_hold++;
        if (!rst && stall && (!rx_valid || rx_data !== prev_rxd)) v_rxhold++;
        if (rx_valid && !rx_ready && m_wen && m_addr == BASE + 32'h8) v_bp++;
        if (done && cs_m) v_cs++;
        if (m_wen && m_addr == BASE + 32'h4 && m_wdata[31:2] !== clkdiv) v_div++;
        pend     = !rst && (m_wen || m_ren) && !m_ready;
        stall    = !rst && rx_valid && !rx_ready;
        prev_bus = {m_addr, m_wdata, m_wmask, m_wen, m_ren};
        prev_rxd = rx_data;
    end

    task automatic do_xfer(input logic [7:0] c, input logic [31:0] a,
                           input int n, input bit stray, output int lat);
        int m0, r0, rl0, d0;
        logic [7:0] eb;
        m0  = mosi.size();
        r0  = rxq.size();
        rl0 = rel_cnt;
        d0  = done_cnt;
        @(negedge clk);
        cmd = c;
        flash_addr = a;
        len = 16'(n);
        start = 1'b1;
        lat = 0;
        while (lat < 20000) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) begin
                start = 1'b0;
                chk("busy_c1", {31'h0, busy}, 1);
            end
            if (stray && lat == 8) begin
                cmd = ~c;
                flash_addr = ~a;
                len = 16'(n + 2);
                start = 1'b1;
            end
            if (stray && lat == 9) start = 1'b0;
            if (done) break;
        end
        chk("done_seen", {31'h0, done}, 1);
        @(negedge clk);
        @(negedge clk);
        chk("idle_after", {31'h0, busy}, 0);
        chk("mosi_n", mosi.size() - m0, 4 + n);
        for (int i = 0; i < 4 + n && m0 + i < mosi.size(); i++) begin
            if (i == 0) eb = c;
            else if (i <= 3) eb = 8'(a >> (8 * (3 - i)));
            else eb = 8'h00;
            chk($sformatf("mosi%0d", i), {24'h0, mosi[m0 + i]}, {24'h0, eb});
        end
        chk("rx_n", rxq.size() - r0, n);
        for (int i = 0; i < n && r0 + i < rxq.size(); i++)
            chk($sformatf("rx%0d", i), {24'h0, rxq[r0 + i]},
                {24'h0, 8'(a[7:0] + 8'(i))});
        chk("release_n", rel_cnt - rl0, 1);
        chk("done_n", done_cnt - d0, 1);
    endtask

    initial begin
        int lat, m0, rl0, d0;
        logic [7:0]  c;
        logic [31:0] a;
        rst = 1'b1;
        start = 1'b0;
        cmd = 8'h0;
        flash_addr = 32'h0;
        len = 16'h0;
        clkdiv = 30'h15;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'h0, busy}, 0);
        chk("rst_done", {31'h0, done}, 0);
        chk("rst_rxv", {31'h0, rx_valid}, 0);
        chk("rst_rxd", {24'h0, rx_data}, 0);
        chk("rst_wen", {31'h0, m_wen}, 0);
        chk("rst_ren", {31'h0, m_ren}, 0);
        chk("rst_addr", m_addr, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("por_release", rel_cnt, 1);
        chk("por_nodone", done_cnt, 0);

        do_xfer(8'h03, 32'h012345, 4, 0, lat);

        do_xfer(8'h03, 32'h00abcd, 0, 0, lat);
        chk("lat_len0", lat, 6 * (1 + 3) + 2);

        bp = 1;
        dly_rand = 1;
        do_xfer(8'h0b, 32'h7711f0, 3, 0, lat);
        bp = 0;
        dly_rand = 0;

        m0 = mosi.size();
        rl0 = rel_cnt;
        d0 = done_cnt;
        @(negedge clk);
        cmd = 8'h03;
        flash_addr = 32'h00beef;
        len = 16'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2000 && mosi.size() < m0 + 3; i++) @(negedge clk);
        chk("abort_reach", mosi.size() - m0, 3);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("abort_wen", {31'h0, m_wen}, 0);
        chk("abort_ren", {31'h0, m_ren}, 0);
        @(posedge clk);
        #1;
        chk("abort_busy", {31'h0, busy}, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 200 && rel_cnt == rl0; i++) @(negedge clk);
        chk("abort_release", rel_cnt - rl0, 1);
        repeat (5) @(negedge clk);
        chk("abort_nodone", done_cnt - d0, 0);
        chk("abort_rxv", {31'h0, rx_valid}, 0);
        do_xfer(8'h03, 32'h012345, 4, 0, lat);

        do_xfer(8'h03, 32'h401000, 3, 1, lat);

        mr_rand = 1;
        do_xfer(8'h03, 32'h012345, 4, 0, lat);

        rr_rand = 1;
        dly_rand = 1;
        for (int k = 0; k < 4; k++) begin
            c = 8'($urandom);
            a = $urandom;
            do_xfer(c, a, int'($urandom_range(0, 5)), 0, lat);
        end
        mr_rand = 0;
        rr_rand = 0;
        dly_rand = 0;

        chk("both_strobes", v_both, 0);
        chk("bus_hold", v_hold, 0);
        chk("rx_hold", v_rxhold, 0);
        chk("load_backpressure", v_bp, 0);
        chk("done_cs_high", v_cs, 0);
        chk("ctl_clkdiv", v_div, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
